// File: rtl/home_pkg.sv
// home_pkg: mode encoding, default timer width and timed-mode helper for the arming controller
package home_pkg;
   localparam logic [2:0] MODE_DISARMED = 3'd0;
   localparam logic [2:0] MODE_EXIT     = 3'd1;
   localparam logic [2:0] MODE_ARMED    = 3'd2;
   localparam logic [2:0] MODE_ENTRY    = 3'd3;
   localparam logic [2:0] MODE_ALARM    = 3'd4;
   localparam int unsigned CNT_W_DEF    = 8;
   function automatic logic is_timed(input logic [2:0] m);
      return (m == MODE_EXIT) || (m == MODE_ENTRY) || (m == MODE_ALARM);
   endfunction
endpackage

// File: rtl/pin_guard.sv
// pin_guard: PIN compare, consecutive wrong-PIN counter and keypad lockout timer
module pin_guard #(
   parameter logic [3:0]  PIN_CODE  = 4'b0000,
   parameter int unsigned LOCK_SEC  = 60,
   parameter int unsigned MAX_TRIES = 3,
   parameter int unsigned CNT_W     = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       pin_valid,
   input  logic [3:0] pin,
   output logic       good_pin,
   output logic       pin_err,
   output logic       locked
);
   localparam int unsigned       TW      = $clog2(MAX_TRIES + 1);
   localparam logic [TW-1:0]     TRY_MAX = TW'(MAX_TRIES);
   localparam logic [CNT_W-1:0]  LOCK_V  = CNT_W'(LOCK_SEC);
   logic [TW-1:0]    try_q, try_d;
   logic [CNT_W-1:0] lock_q, lock_d;
   logic             locked_q, locked_d, err_q, bad_pin, try_full;
   assign good_pin = pin_valid & ~locked_q & (pin == PIN_CODE);
   assign bad_pin  = pin_valid & ~locked_q & (pin != PIN_CODE);
   assign try_full = bad_pin & (try_q + 1'b1 >= TRY_MAX);
   // reaching the limit starts the lockout and clears the count in the same cycle
   always_comb begin
      try_d    = (good_pin | try_full) ? '0 : bad_pin ? try_q + 1'b1 : try_q;
      locked_d = try_full | (locked_q & ~(tick & (lock_q == CNT_W'(1))));
      lock_d   = try_full ? LOCK_V : (locked_q & tick) ? lock_q - 1'b1 : lock_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         try_q    <= '0;
         lock_q   <= '0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         try_q    <= try_d;
         lock_q   <= lock_d;
         locked_q <= locked_d;
         err_q    <= bad_pin;
      end
   end
   assign pin_err = err_q;
   assign locked  = locked_q;
endmodule

// File: rtl/security_arm_controller.sv
// security_arm_controller: arming mode FSM with a shared exit/entry/alarm delay timer
module security_arm_controller
   import home_pkg::*;
#(
   parameter logic [3:0]  PIN_CODE  = 4'b0000,
   parameter int unsigned EXIT_SEC  = 30,
   parameter int unsigned ENTRY_SEC = 15,
   parameter int unsigned ALARM_SEC = 180,
   parameter int unsigned LOCK_SEC  = 60,
   parameter int unsigned MAX_TRIES = 3,
   parameter int unsigned CNT_W     = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             arm_req,
   input  logic             pin_valid,
   input  logic [3:0]       pin,
   input  logic [4:0]       motion,
   output logic [2:0]       mode,
   output logic             siren,
   output logic             exit_beep,
   output logic             pin_err,
   output logic             locked,
   output logic [CNT_W-1:0] remaining
);
   logic [2:0]       mode_q, mode_d;
   logic [CNT_W-1:0] tmr_q, tmr_d;
   logic             siren_q, beep_q, good_pin, expire, moving;
   pin_guard #(
      .PIN_CODE (PIN_CODE),
      .LOCK_SEC (LOCK_SEC),
      .MAX_TRIES(MAX_TRIES),
      .CNT_W    (CNT_W)
   ) u_guard (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .pin_valid(pin_valid),
      .pin      (pin),
      .good_pin (good_pin),
      .pin_err  (pin_err),
      .locked   (locked)
   );
   assign moving = |motion;
   assign expire = tick & is_timed(mode_q) & (tmr_q == CNT_W'(1));
   // loading a new mode's delay takes precedence over a coincident tick
   always_comb begin
      mode_d = mode_q;
      tmr_d  = (tick & is_timed(mode_q)) ? tmr_q - 1'b1 : tmr_q;
      if (good_pin) begin
         mode_d = MODE_DISARMED;
         tmr_d  = '0;
      end else begin
         case (mode_q)
            MODE_DISARMED: if (arm_req & ~moving) begin
               mode_d = MODE_EXIT;
               tmr_d  = CNT_W'(EXIT_SEC);
            end
            MODE_EXIT: if (expire) begin
               mode_d = MODE_ARMED;
               tmr_d  = '0;
            end
            MODE_ARMED: if (moving) begin
               mode_d = MODE_ENTRY;
               tmr_d  = CNT_W'(ENTRY_SEC);
            end
            MODE_ENTRY: if (expire) begin
               mode_d = MODE_ALARM;
               tmr_d  = CNT_W'(ALARM_SEC);
            end
            MODE_ALARM: if (expire) begin
               mode_d = MODE_ARMED;
               tmr_d  = '0;
            end
            default: begin
               mode_d = MODE_DISARMED;
               tmr_d  = '0;
            end
         endcase
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q  <= MODE_DISARMED;
         tmr_q   <= '0;
         siren_q <= 1'b0;
         beep_q  <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         tmr_q   <= tmr_d;
         siren_q <= (mode_d == MODE_ALARM);
         beep_q  <= (mode_d == MODE_EXIT);
      end
   end
   assign mode      = mode_q;
   assign remaining = tmr_q;
   assign siren     = siren_q;
   assign exit_beep = beep_q;
endmodule

// File: tb/tb_security_arm_controller.sv
// tb_security_arm_controller: directed checks of arming, intrusion, disarm race, lockout and reset
module tb_security_arm_controller;
   logic       clk, rst_n, tick, arm_req, pin_valid, siren, exit_beep, pin_err, locked;
   logic [3:0] pin;
   logic [4:0] motion;
   logic [2:0] mode;
   logic [7:0] remaining;
   int         checks = 0;
   int         errors = 0;

   security_arm_controller #(
      .PIN_CODE (4'b0000),
      .EXIT_SEC (3),
      .ENTRY_SEC(2),
      .ALARM_SEC(4),
      .LOCK_SEC (5),
      .MAX_TRIES(3),
      .CNT_W    (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .arm_req  (arm_req),
      .pin_valid(pin_valid),
      .pin      (pin),
      .motion   (motion),
      .mode     (mode),
      .siren    (siren),
      .exit_beep(exit_beep),
      .pin_err  (pin_err),
      .locked   (locked),
      .remaining(remaining)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic do_arm();
      arm_req = 1'b1;
      step();
      arm_req = 1'b0;
   endtask

   task automatic do_pin(input logic [3:0] p);
      pin       = p;
      pin_valid = 1'b1;
      step();
      pin_valid = 1'b0;
   endtask

   task automatic do_motion(input logic [4:0] m);
      motion = m;
      step();
      motion = '0;
   endtask

   initial begin
      rst_n = 1'b0; tick = 1'b0; arm_req = 1'b0; pin_valid = 1'b0; pin = '0; motion = '0;
      #2;
      check("rst_mode", 32'(mode), 32'd0);
      check("rst_rem", 32'(remaining), 32'd0);
      check("rst_outs", {28'd0, siren, exit_beep, pin_err, locked}, 32'd0);
      step(); step();
      rst_n = 1'b1;
      step();
      // arm and exit delay
      do_arm();
      check("arm_mode", 32'(mode), 32'd1);
      check("arm_rem", 32'(remaining), 32'd3);
      check("arm_beep", 32'(exit_beep), 32'd1);
      do_tick(); do_tick();
      check("exit_rem1", 32'(remaining), 32'd1);
      check("exit_mode1", 32'(mode), 32'd1);
      do_tick();
      check("armed_mode", 32'(mode), 32'd2);
      check("armed_beep", 32'(exit_beep), 32'd0);
      check("armed_rem", 32'(remaining), 32'd0);
      do_arm();
      check("arm_in_armed", 32'(mode), 32'd2);
      // intrusion, alarm, auto re-arm
      do_motion(5'b00100);
      check("entry_mode", 32'(mode), 32'd3);
      check("entry_rem", 32'(remaining), 32'd2);
      do_tick();
      check("entry_rem1", 32'(remaining), 32'd1);
      do_tick();
      check("alarm_mode", 32'(mode), 32'd4);
      check("alarm_siren", 32'(siren), 32'd1);
      check("alarm_rem", 32'(remaining), 32'd4);
      do_tick(); do_tick(); do_tick();
      check("alarm_rem1", 32'(remaining), 32'd1);
      check("alarm_siren3", 32'(siren), 32'd1);
      do_tick();
      check("rearm_mode", 32'(mode), 32'd2);
      check("rearm_siren", 32'(siren), 32'd0);
      // good pin coinciding with the final entry tick wins
      do_motion(5'b00100);
      do_tick();
      check("race_pre", 32'(remaining), 32'd1);
      tick = 1'b1;
      do_pin(4'b0000);
      tick = 1'b0;
      check("race_mode", 32'(mode), 32'd0);
      check("race_siren", 32'(siren), 32'd0);
      check("race_rem", 32'(remaining), 32'd0);
      step();
      check("race_siren2", 32'(siren), 32'd0);
      // blocked arm
      motion = 5'b00001;
      do_arm();
      motion = '0;
      check("blocked_arm", 32'(mode), 32'd0);
      // lockout during exit delay
      do_arm();
      check("lk_exit", 32'(mode), 32'd1);
      do_pin(4'b1010);
      check("lk_err1", {30'd0, pin_err, locked}, 32'd2);
      step();
      check("lk_err1_off", 32'(pin_err), 32'd0);
      do_pin(4'b1010);
      check("lk_err2", {30'd0, pin_err, locked}, 32'd2);
      do_pin(4'b1010);
      check("lk_err3", {30'd0, pin_err, locked}, 32'd3);
      do_pin(4'b0000);
      check("lk_ignored_mode", 32'(mode), 32'd1);
      check("lk_ignored_err", {30'd0, pin_err, locked}, 32'd1);
      do_tick(); do_tick(); do_tick(); do_tick();
      check("lk_still", 32'(locked), 32'd1);
      check("lk_mode_armed", 32'(mode), 32'd2);
      do_tick();
      check("lk_release", 32'(locked), 32'd0);
      do_pin(4'b1010);
      check("lk_count_clear", {30'd0, pin_err, locked}, 32'd2);
      check("lk_bad_mode", 32'(mode), 32'd2);
      do_pin(4'b0000);
      check("lk_good_mode", 32'(mode), 32'd0);
      check("lk_good_err", 32'(pin_err), 32'd0);
      // async reset mid-alarm while locked
      do_arm();
      do_tick(); do_tick(); do_tick();
      do_motion(5'b10000);
      do_tick(); do_tick();
      do_pin(4'b0110); do_pin(4'b0110); do_pin(4'b0110);
      check("pre_rst_state", {27'd0, mode, siren, locked}, {27'd0, 3'd4, 1'b1, 1'b1});
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_outs", {20'd0, mode, remaining, siren, exit_beep, pin_err, locked}, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      check("post_rst_mode", 32'(mode), 32'd0);
      check("post_rst_locked", 32'(locked), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
